// File: rtl/blink_rate_ctrl_pkg.sv
// Shared definitions for the blink rate controller: FSM encoding, rate-mode
// sizing and the default base half-period.
`ifndef ENV_BASIC_FREQ
`define ENV_BASIC_FREQ 16
`endif
package blink_rate_ctrl_pkg;

  localparam int unsigned MODE_CNT = 4;
  localparam int unsigned MODE_W   = 2;

  typedef logic [MODE_W-1:0] mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Simulation builds use a short half-period; hardware takes the board clock define.
`ifdef DEBUG_TEST_BENCH
  localparam int unsigned HALF_DEFAULT = 16;
`else
  localparam int unsigned HALF_DEFAULT = `ENV_BASIC_FREQ;
`endif

  function automatic mode_t next_mode(input mode_t m);
    return (m == mode_t'(MODE_CNT - 1)) ? '0 : m + mode_t'(1);
  endfunction

endpackage

// File: rtl/half_period_timer.sv
// Cycle counter with terminal-count compare; pulses boundary on the last
// cycle of each half-period and restarts from zero.
module half_period_timer #(
  parameter int unsigned P_CNT_W = 32
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [P_CNT_W-1:0] limit,
  output logic               boundary
);

  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic               tc;

  assign tc       = (cnt_q == limit - P_CNT_W'(1));
  assign boundary = enable && !clear && tc;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tc ? '0 : cnt_q + P_CNT_W'(1);
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// Square-wave blinker with four selectable rates; rate changes requested by a
// button pulse are deferred to the next half-period boundary.
//   state | meaning
//   IDLE  | disabled, counter held at 0, out_sig frozen
//   RUN   | counting, no change latched
//   PEND  | counting, mode change latched for the next boundary
module blink_rate_ctrl
  import blink_rate_ctrl_pkg::*;
#(
  parameter int unsigned P_HALF  = HALF_DEFAULT,
  parameter int unsigned P_CNT_W = 32
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_en,
  input  logic              in_req,
  output logic              out_sig,
  output logic [MODE_W-1:0] out_mode,
  output logic              out_pending,
  output logic              out_drop
);

  state_e             state_q, state_d;
  logic               sig_q, sig_d;
  mode_t              mode_q, mode_d;
  logic               pending_q, pending_d;
  logic               drop_q, drop_d;
  logic               tmr_enable;
  logic               tmr_clear;
  logic               boundary;
  logic [P_CNT_W-1:0] half_len;

  assign half_len   = P_CNT_W'(P_HALF >> mode_q);
  assign tmr_enable = in_en && (state_q != ST_IDLE);
  // Dropping enable clears the count in the same edge that enters IDLE.
  assign tmr_clear  = !tmr_enable;

  half_period_timer #(
    .P_CNT_W (P_CNT_W)
  ) u_timer (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .limit    (half_len),
    .boundary (boundary)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= ST_IDLE;
      sig_q     <= 1'b0;
      mode_q    <= '0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!in_en)      state_d = ST_IDLE;
        else if (in_req) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!in_en)        state_d = ST_IDLE;
        else if (boundary) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sig_d     = sig_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    drop_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_req) mode_d = next_mode(mode_q);
      end
      ST_RUN: begin
        if (in_en) begin
          // A request on a boundary still finishes that boundary in the old mode.
          if (boundary) sig_d = ~sig_q;
          if (in_req) pending_d = 1'b1;
        end
      end
      ST_PEND: begin
        if (!in_en) begin
          mode_d    = next_mode(mode_q);
          pending_d = 1'b0;
        end else begin
          if (boundary) begin
            sig_d     = ~sig_q;
            mode_d    = next_mode(mode_q);
            pending_d = 1'b0;
          end
          if (in_req) drop_d = 1'b1;
        end
      end
      default: begin
        pending_d = 1'b0;
      end
    endcase
  end

  assign out_sig     = sig_q;
  assign out_mode    = mode_q;
  assign out_pending = pending_q;
  assign out_drop    = drop_q;

endmodule
